bus_driver_arbiter: RTL and testbench
=====================================

Name: bus_driver_arbiter

Overview:
- Single-driver resolution stage that sits in front of a shared bus where several sources would otherwise drive the same net.
- Accepts up to N requesters and grants exactly one per transfer using round-robin priority.
- Registers the winner's data and drives the bus from a single always block, so the bus has exactly one driver.
- Presents a valid/ready handshake to the downstream consumer.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, data width per requester and bus width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  per-requester request, level-sensitive
- data_in  input  N*W  packed requester data; requester i occupies bits [i*W +: W]
- ready  input  1  downstream accepts bus_out when high with bus_valid
- bus_out  output  W  registered data of the granted requester
- bus_valid  output  1  bus_out holds a pending transfer
- grant  output  N  one-hot, granted requester; all zero when idle
- conflict  output  1  one-cycle pulse: more than one req bit high in a cycle where state is IDLE
- conflict_cnt  output  8  conflict counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, bus_out=0, bus_valid=0, grant=0, conflict=0, conflict_cnt=0.
  - Round-robin pointer ptr=0.
  - Reset mid-transfer discards the pending word; no transfer completes.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE; outputs hold their idle values.
  - Else select winner g: the first set req bit searching from index ptr upward, wrapping modulo N.
  - On the next edge: bus_out<=data_in[g], grant<=one-hot(g), bus_valid<=1, state<=BUSY.
  - Latency: req seen at edge t gives bus_valid=1 after edge t.
- BUSY:
  - bus_out and grant are held stable while ready=0; there is no timeout.
  - On an edge with ready=1: transfer completes, bus_valid<=0, grant<=0, ptr<=(g+1) mod N, state<=IDLE.
  - This forces a one-cycle bubble between grants. bus_out keeps its last value; it is don't-care while bus_valid=0.
- Requests:
  - req changes while BUSY are ignored. A granted requester that drops req does not cancel its transfer; the data was captured at grant.
  - A requester must keep req high to be considered in IDLE. Dropped requests are not remembered.
- conflict:
  - Registered. conflict<=1 on the edge where state==IDLE and popcount(req)>=2; otherwise 0.
- Fairness:
  - With all N requesters held high continuously, grants rotate 0,1,...,N-1,0,...
  - Each requester is granted within N transfers.
- Wrap-around:
  - ptr=N-1 followed by a grant to N-1 wraps ptr to 0.
  - The search wraps past index N-1 to index 0.
- Single driver: bus_out, bus_valid, grant and state are each assigned in exactly one always block. No continuous assign targets a registered output.

Optional Feature:
- Macro: BUS_ARB_CONFLICT_COUNT_EN.
- Defined:
  - conflict_cnt is an 8-bit counter that increments on each edge where conflict is set.
  - It saturates at 255 and does not wrap.
  - It is cleared only by rst.
- Undefined:
  - conflict_cnt is tied to 8'd0 and the counter logic is absent.
  - The conflict pulse remains present in both builds.

Test Plan:
- Reset: assert rst mid-BUSY with bus_valid=1 -> same cycle bus_valid=0, grant=0, bus_out=0; after release, req=4'b0100 -> grant=4'b0100 and bus_out=data_in[2] one edge later.
- Single request: req=4'b0010, data_in lane1=8'hA5, ready=1 -> grant=0010, bus_out=A5, bus_valid=1 for one cycle; IDLE next; ptr=2.
- Round-robin: req=4'b1111 held, ready=1, lanes 8'h10/11/12/13 -> bus_out sequence 10,11,12,13,10 on alternate cycles; conflict=1 after each IDLE cycle.
- Backpressure: grant lane3 (8'h5C), ready=0 for 5 cycles while req changes to 4'b0001 -> bus_out stays 5C and grant stays 1000; ready=1 completes the transfer; the next grant is lane0 via wrap.
- Drop after grant: req=4'b0001 for one cycle only, ready low 3 cycles -> transfer still completes with the captured data.
- Counter, macro defined: 300 IDLE cycles with req=4'b0011 and ready=1 -> conflict_cnt saturates at 8'd255. Macro undefined -> conflict_cnt=0 throughout.

Source files
------------

// File: rtl/bus_driver_arbiter_if.sv
// bus_driver_arbiter_if
// Request, data and valid/ready bundle shared by the requesters, the
// bus_driver_arbiter and the downstream consumer of the resolved bus.
//   master : the arbiter side (drives the bus and status outputs)
//   slave  : the environment side (requesters plus the consumer)

interface bus_driver_arbiter_if #(
    parameter int N = 4,
    parameter int W = 8
);
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           ready;
    logic [W-1:0]   bus_out;
    logic           bus_valid;
    logic [N-1:0]   grant;
    logic           conflict;
    logic [7:0]     conflict_cnt;

    modport master (
        input  req,
        input  data_in,
        input  ready,
        output bus_out,
        output bus_valid,
        output grant,
        output conflict,
        output conflict_cnt
    );

    modport slave (
        output req,
        output data_in,
        output ready,
        input  bus_out,
        input  bus_valid,
        input  grant,
        input  conflict,
        input  conflict_cnt
    );
endinterface

// File: rtl/bus_driver_arbiter.sv
// bus_driver_arbiter
// Single-driver resolution stage for a shared bus. Up to N requesters are
// arbitrated round-robin; the winner's word is captured into a register that
// is the only driver of the bus, and is offered downstream with valid/ready.
// Each accepted transfer is followed by one IDLE cycle before the next grant.
//
// Optional build macro BUS_ARB_CONFLICT_COUNT_EN: when defined, conflict_cnt
// is a saturating 8-bit count of conflict pulses; otherwise it is tied to 0.

module bus_driver_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_driver_arbiter_if.master  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // Round-robin search start, and index of the requester currently owning the bus.
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_nxt;

    // Winner of the current search.
    logic            found;
    logic [PW-1:0]   win;

    // Next values of the registered outputs.
    logic [W-1:0]    bus_out_nxt;
    logic            bus_valid_nxt;
    logic [N-1:0]    grant_nxt;
    logic            conflict_nxt;

    // Round-robin search: first set req bit starting at ptr, wrapping past N-1 to 0.
    always_comb begin
        int            idx;
        logic [PW-1:0] pos;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            pos = PW'(idx);
            if (!found && bus.req[pos]) begin
                found = 1'b1;
                win   = pos;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave IDLE on any request, leave BUSY when the consumer accepts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)     state_nxt = BUSY;
            BUSY:    if (bus.ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output decode: what the bus, grant, pointer and conflict flag become on the next edge.
    always_comb begin
        bus_out_nxt   = bus.bus_out;
        bus_valid_nxt = bus.bus_valid;
        grant_nxt     = bus.grant;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        case (state)
            IDLE: begin
                if (found) begin
                    // Capture the winner's word now; later req/data changes cannot disturb it.
                    for (int i = 0; i < N; i++) begin
                        if (win == PW'(i)) begin
                            bus_out_nxt = bus.data_in[i*W +: W];
                        end
                    end
                    grant_nxt     = N'(1) << win;
                    bus_valid_nxt = 1'b1;
                    owner_nxt     = win;
                end
            end
            BUSY: begin
                // Held with no timeout until the consumer takes the word.
                if (bus.ready) begin
                    bus_valid_nxt = 1'b0;
                    grant_nxt     = '0;
                    ptr_nxt       = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                bus_valid_nxt = 1'b0;
                grant_nxt     = '0;
            end
        endcase
        // More than one contender while arbitrating.
        conflict_nxt = (state == IDLE) && ($countones(bus.req) >= 2);
    end

    // Output and pointer registers: the single driver of the bus and its status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.bus_out   <= '0;
            bus.bus_valid <= 1'b0;
            bus.grant     <= '0;
            bus.conflict  <= 1'b0;
            ptr           <= '0;
            owner         <= '0;
        end else begin
            bus.bus_out   <= bus_out_nxt;
            bus.bus_valid <= bus_valid_nxt;
            bus.grant     <= grant_nxt;
            bus.conflict  <= conflict_nxt;
            ptr           <= ptr_nxt;
            owner         <= owner_nxt;
        end
    end

`ifdef BUS_ARB_CONFLICT_COUNT_EN
    // Saturating conflict counter; counts on the same edge that raises the conflict pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.conflict_cnt <= 8'd0;
        end else if (conflict_nxt && (bus.conflict_cnt != 8'hFF)) begin
            bus.conflict_cnt <= bus.conflict_cnt + 8'd1;
        end
    end
`else
    assign bus.conflict_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_bus_driver_arbiter.sv
// tb_bus_driver_arbiter
// Directed stimulus for bus_driver_arbiter. Each scenario pushes the
// transfers it expects into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT completes a transfer (bus_valid & ready).
// Cycle-accurate details (latency, hold, reset, conflict, counter) are
// compared directly by the stimulus thread.

`timescale 1ns/1ps

module tb_bus_driver_arbiter;

    localparam int N = 4;
    localparam int W = 8;

`ifdef BUS_ARB_CONFLICT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] grant;
        logic [W-1:0] data;
    } xfer_t;

    logic  clk = 1'b0;
    logic  rst;
    xfer_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    bus_driver_arbiter_if #(.N(N), .W(W)) bus();

    bus_driver_arbiter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] v);
        bus.data_in[i*W +: W] = v;
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    // Monitor: every accepted transfer must match the oldest expected one.
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.bus_valid && bus.ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL xfer_unexpected: got grant %0h data %0h, expected no transfer",
                             bus.grant, bus.bus_out);
                end else begin
                    e = sb_q.pop_front();
                    check("xfer_grant", 32'(bus.grant), 32'(e.grant));
                    check("xfer_data", 32'(bus.bus_out), 32'(e.data));
                end
            end
        end
    end

    // Watchdog: the run is a fixed sequence of ticks, this only guards against a stuck clock.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;
        bus.ready   = 1'b0;
        #2;
        // Reset state.
        check("rst_valid", 32'(bus.bus_valid), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_bus_out", 32'(bus.bus_out), 32'd0);
        check("rst_conflict", 32'(bus.conflict), 32'd0);
        check("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset mid-BUSY discards the pending word.
        set_lane(0, 8'h77);
        bus.req = 4'b0001;
        tick();
        check("pre_rst_valid", 32'(bus.bus_valid), 32'd1);
        check("pre_rst_grant", 32'(bus.grant), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.bus_valid), 32'd0);
        check("midrst_grant", 32'(bus.grant), 32'd0);
        check("midrst_bus_out", 32'(bus.bus_out), 32'd0);
        tick();
        rst = 1'b0;
        set_lane(2, 8'hC3);
        bus.req   = 4'b0100;
        bus.ready = 1'b1;
        sb_q.push_back({4'b0100, 8'hC3});
        tick();
        check("post_rst_grant", 32'(bus.grant), 32'h4);
        check("post_rst_bus_out", 32'(bus.bus_out), 32'hC3);
        bus.req = '0;
        tick();

        // Single request, consumer always ready.
        set_lane(1, 8'hA5);
        bus.req = 4'b0010;
        sb_q.push_back({4'b0010, 8'hA5});
        tick();
        check("single_valid", 32'(bus.bus_valid), 32'd1);
        check("single_grant", 32'(bus.grant), 32'h2);
        check("single_conflict", 32'(bus.conflict), 32'd0);
        bus.req = '0;
        tick();
        check("single_idle_valid", 32'(bus.bus_valid), 32'd0);
        check("single_idle_grant", 32'(bus.grant), 32'd0);

        // Round-robin from a freshly reset pointer, all requesters held high.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 8'(8'h10 + i));
        bus.req = 4'b1111;
        sb_q.push_back({4'b0001, 8'h10});
        sb_q.push_back({4'b0010, 8'h11});
        sb_q.push_back({4'b0100, 8'h12});
        sb_q.push_back({4'b1000, 8'h13});
        sb_q.push_back({4'b0001, 8'h10});
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 9) bus.req = '0;
            check("rr_valid", 32'(bus.bus_valid), 32'(i % 2));
            check("rr_conflict", 32'(bus.conflict), 32'(i % 2));
        end
        check("rr_cnt", 32'(bus.conflict_cnt), cnt_exp(5));

        // Backpressure on lane 3, then a wrapped pointer picks lane 0 over lane 3.
        set_lane(3, 8'h5C);
        set_lane(0, 8'hE0);
        bus.ready = 1'b0;
        bus.req   = 4'b1000;
        sb_q.push_back({4'b1000, 8'h5C});
        tick();
        check("bp_grant0", 32'(bus.grant), 32'h8);
        bus.req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", 32'(bus.bus_out), 32'h5C);
            check("bp_hold_grant", 32'(bus.grant), 32'h8);
            check("bp_hold_valid", 32'(bus.bus_valid), 32'd1);
        end
        bus.ready = 1'b1;
        bus.req   = 4'b1001;
        sb_q.push_back({4'b0001, 8'hE0});
        tick();
        check("bp_bubble_valid", 32'(bus.bus_valid), 32'd0);
        tick();
        check("wrap_grant", 32'(bus.grant), 32'h1);
        check("wrap_bus_out", 32'(bus.bus_out), 32'hE0);
        bus.req = '0;
        tick();
        check("bp_cnt", 32'(bus.conflict_cnt), cnt_exp(6));

        // Requester drops req right after grant; captured word still delivered.
        set_lane(0, 8'h3C);
        bus.ready = 1'b0;
        bus.req   = 4'b0001;
        sb_q.push_back({4'b0001, 8'h3C});
        tick();
        bus.req = '0;
        set_lane(0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop_hold_valid", 32'(bus.bus_valid), 32'd1);
            check("drop_hold_data", 32'(bus.bus_out), 32'h3C);
        end
        bus.ready = 1'b1;
        tick();
        check("drop_done_valid", 32'(bus.bus_valid), 32'd0);

        // 300 conflicting IDLE cycles: the counter saturates instead of wrapping.
        set_lane(0, 8'hA0);
        set_lane(1, 8'hA1);
        bus.req = 4'b0011;
        for (int k = 0; k < 300; k++) begin
            if (k % 2 == 0) sb_q.push_back({4'b0010, 8'hA1});
            else            sb_q.push_back({4'b0001, 8'hA0});
        end
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (i == 599) bus.req = '0;
            if (i == 200) check("cnt_mid", 32'(bus.conflict_cnt), cnt_exp(106));
        end
        check("cnt_sat", 32'(bus.conflict_cnt), cnt_exp(255));

        tick();
        tick();
        check("final_valid", 32'(bus.bus_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
